// File: rtl/des_pkg.sv
// Shared types and the per-bit combine rule for the des_pipe_gen benchmark.
package des_pkg;

    typedef enum logic [1:0] {
        MODE_RISE   = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_FALL   = 2'd2,
        MODE_PASS   = 2'd3
    } mode_t;

    // Combine one bit of the current beat with the same bit of the previous beat.
    function automatic logic combine(mode_t m, logic prev, logic cur);
        logic r;
        case (m)
            MODE_RISE:   r = ~prev & cur;
            MODE_TOGGLE: r = prev ^ cur;
            MODE_FALL:   r = prev & ~cur;
            default:     r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pipe_stage.sv
// One elastic valid/data register slice; takes a new beat whenever it is
// empty or its current beat is leaving in the same cycle.
module des_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             v;
    logic [WIDTH-1:0] d;

    assign in_ready  = !v || out_ready;
    assign out_valid = v;
    assign out_data  = d;

    // Slice register: flush drops the valid bit but leaves the data in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            if (flush)
                v <= 1'b0;
            else if (in_ready)
                v <= in_valid;
            if (in_ready && in_valid && !flush)
                d <= in_data;
        end
    end

endmodule

// File: rtl/des_pipe_gen.sv
// Edge/toggle-detect stream benchmark: combine each accepted beat with the
// previous one, push it through DEPTH elastic stages, count output transfers.
module des_pipe_gen
    import des_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int INV_OUT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] comb;
    logic             acc;
    logic             s0_ready;
    logic             last_valid;
    logic [WIDTH-1:0] last_data;

    assign in_ready = rst_n && !flush && s0_ready;
    assign acc      = in_valid && in_ready;

    // Bitwise combine of the incoming beat with the last accepted beat.
    always_comb begin
        comb = '0;
        for (int unsigned b = 0; b < WIDTH; b++)
            comb[b] = combine(mode_t'(mode), prev[b], in_data[b]);
    end

    // Previous-beat register, updated on every acceptance regardless of mode.
    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            prev <= '0;
        else if (acc)
            prev <= in_data;
    end

    // Each stage's ready comes from the stage after it, so the chain is wired
    // through per-iteration signals rather than one shared array.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             dn_ready;
        logic             rdy;
        logic             vld;
        logic [WIDTH-1:0] dat;

        if (i == 0) begin : g_first
            assign up_valid = acc;
            assign up_data  = comb;
        end else begin : g_mid
            assign up_valid = g_stage[i-1].vld;
            assign up_data  = g_stage[i-1].dat;
        end

        if (i == DEPTH - 1) begin : g_last
            assign dn_ready = out_ready;
        end else begin : g_inner
            assign dn_ready = g_stage[i+1].rdy;
        end

        des_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (up_valid),
            .in_ready  (rdy),
            .in_data   (up_data),
            .out_valid (vld),
            .out_ready (dn_ready),
            .out_data  (dat)
        );
    end

    assign s0_ready   = g_stage[0].rdy;
    assign last_valid = g_stage[DEPTH-1].vld;
    assign last_data  = g_stage[DEPTH-1].dat;

    assign out_valid = last_valid;
    assign out_data  = (INV_OUT != 0) ? ~last_data : last_data;

    // Saturating count of output handshakes; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            xfer_cnt <= '0;
        else if (out_valid && out_ready && (xfer_cnt != '1))
            xfer_cnt <= xfer_cnt + 1'b1;
    end

endmodule

// File: tb/tb_des_pipe_gen.sv
// Scoreboard bench: two lockstep instances (plain output / inverted output with
// a 4-bit counter) share all inputs; a reference model predicts each output.
module tb_des_pipe_gen;

    localparam int W = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, flush, in_valid, out_ready;
    logic [1:0]   mode;
    logic [W-1:0] in_data;

    logic         in_ready_a, out_valid_a;
    logic [W-1:0] out_data_a;
    logic [15:0]  cnt_a;
    logic         in_ready_b, out_valid_b;
    logic [W-1:0] out_data_b;
    logic [3:0]   cnt_b;

    des_pipe_gen #(.WIDTH(W), .DEPTH(D), .INV_OUT(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .xfer_cnt(cnt_a)
    );

    des_pipe_gen #(.WIDTH(W), .DEPTH(D), .INV_OUT(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .xfer_cnt(cnt_b)
    );

    typedef struct {
        logic [W-1:0]    data;
        bit              timed;
        longint unsigned t;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mprev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_combine(logic [1:0] m, logic [W-1:0] p, logic [W-1:0] c);
        case (m)
            2'd0:    return ~p & c;
            2'd1:    return p ^ c;
            2'd2:    return p & ~c;
            default: return c;
        endcase
    endfunction

    // One stimulus cycle: drive after the edge, predict acceptance at the
    // falling edge, retire flushed/reset contents after the next rising edge.
    task automatic cycle(input logic rn, input logic v, input logic [W-1:0] d,
                         input logic [1:0] m, input logic ordy, input logic fl,
                         input bit timed = 1'b0);
        logic exp_rdy;
        rst_n = rn; in_valid = v; in_data = d; mode = m; out_ready = ordy; flush = fl;
        @(negedge clk);
        exp_rdy = rn && !fl && ((q.size() < D) || ordy);
        check("in_ready", {63'd0, in_ready_a}, {63'd0, exp_rdy});
        check("in_ready_inv", {63'd0, in_ready_b}, {63'd0, exp_rdy});
        if (v && exp_rdy) begin
            q.push_back('{ref_combine(m, mprev, d), timed, $time});
            mprev = d;
        end
        if (!rn || fl) mprev = '0;
        @(posedge clk);
        #1;
        if (!rn || fl) q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 8'hFF, 2'd0, 1'b1, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin : monitor
        int           exp_cnt;
        bit           stalled;
        logic [W-1:0] held;
        exp_t         e;
        logic [W-1:0] inv;
        exp_cnt = 0;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                exp_cnt = 0;
                stalled = 1'b0;
            end else begin
                check("xfer_cnt", {48'd0, cnt_a}, 64'(exp_cnt > 65535 ? 65535 : exp_cnt));
                check("xfer_cnt_sat", {60'd0, cnt_b}, 64'(exp_cnt > 15 ? 15 : exp_cnt));
                check("out_valid_lockstep", {63'd0, out_valid_b}, {63'd0, out_valid_a});
                if (stalled && out_valid_a)
                    check("stall_stable", {56'd0, out_data_a}, {56'd0, held});
                if (out_valid_a && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected no beat at %0t", out_data_a, $time);
                    end else begin
                        e   = q.pop_front();
                        inv = ~e.data;
                        check("out_data", {56'd0, out_data_a}, {56'd0, e.data});
                        check("out_data_inv", {56'd0, out_data_b}, {56'd0, inv});
                        if (e.timed)
                            check("latency", ($time - e.t) / 10, 64'(D));
                    end
                    exp_cnt++;
                end
                stalled = out_valid_a && !out_ready;
                held    = out_data_a;
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0; in_data = '0;

        // Reset state
        do_reset();
        check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        check("rst_out_data", {56'd0, out_data_a}, 64'h00);
        check("rst_out_data_inv", {56'd0, out_data_b}, 64'hFF);
        check("rst_cnt", {48'd0, cnt_a}, 64'd0);
        idle(1);

        // RISE stream, back to back, latency DEPTH
        cycle(1'b1, 1'b1, 8'h0F, 2'd0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h3C, 2'd0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("rise_cnt", {48'd0, cnt_a}, 64'd2);

        // TOGGLE stream after reset
        do_reset();
        cycle(1'b1, 1'b1, 8'hAA, 2'd1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h55, 2'd1, 1'b1, 1'b0, 1'b1);
        idle(4);

        // Backpressure: two fit, third waits until out_ready rises
        do_reset();
        cycle(1'b1, 1'b1, 8'h11, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h22, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'h33, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h33, 2'd3, 1'b1, 1'b0);
        idle(5);
        check("bp_cnt", {48'd0, cnt_a}, 64'd3);

        // Flush with a beat offered and an output handshake in the same cycle
        cycle(1'b1, 1'b1, 8'h44, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h66, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 2'd1, 1'b1, 1'b1);
        check("flush_out_valid", {63'd0, out_valid_a}, 64'd0);
        cycle(1'b1, 1'b1, 8'h01, 2'd0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("flush_cnt", {48'd0, cnt_a}, 64'd5);

        // PASS beat seen inverted on the second instance
        cycle(1'b1, 1'b1, 8'h5A, 2'd3, 1'b1, 1'b0, 1'b1);
        idle(4);

        // Random traffic, with a reset in the middle discarding in-flight beats
        for (int i = 0; i < 150; i++)
            cycle(1'b1, 1'($urandom_range(3) != 0), 8'($urandom), 2'($urandom),
                  1'($urandom_range(4) != 0), 1'($urandom_range(39) == 0));
        cycle(1'b1, 1'b1, 8'h99, 2'd1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 200; i++)
            cycle(1'b1, 1'($urandom_range(3) != 0), 8'($urandom), 2'($urandom),
                  1'($urandom_range(2) != 0), 1'($urandom_range(39) == 0));
        idle(6);
        check("drained", 64'(q.size()), 64'd0);

        // Counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++)
            cycle(1'b1, 1'b1, 8'(i * 7 + 3), 2'd3, 1'b1, 1'b0, 1'b1);
        idle(5);
        check("sat_cnt_b", {60'd0, cnt_b}, 64'd15);
        check("sat_cnt_a", {48'd0, cnt_a}, 64'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
